// File: rtl/seq_repcode_encoder.sv
// seq_repcode_encoder
// Sits between the sequence serializer and the entropy coder. Converts raw
// match offsets into offBase codes, accumulates per-block byte totals and
// presents the result through a single valid/ready register stage.
//
// Build option: define REPCODE_EN to enable the 3-entry repeat-offset history
// and repeat-code substitution. Without it every non-delimiter sequence is
// coded as a new offset (offset+3).
//
// Width defaults come from SEQ_LL_BITS / SEQ_ML_BITS / SEQ_OFFSET_BITS when
// the surrounding build does not provide them.

`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 20
`endif

// Simulation-only protocol checker: a delimiter sequence carries literals only.
module seq_repcode_encoder_chk #(
   parameter int ML_BITS = `SEQ_ML_BITS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_accept,
   input  logic               i_delim,
   input  logic [ML_BITS-1:0] i_ml
);

   // Abort the run if a delimiter is accepted with a non-zero match length.
   always_ff @(posedge clk) begin
      if (rst_n && i_accept && i_delim && (i_ml != ML_BITS'(0))) begin
         $fatal(1, "seq_repcode_encoder: delimiter sequence accepted with non-zero match length");
      end
   end

endmodule

module seq_repcode_encoder #(
   parameter int LL_BITS          = `SEQ_LL_BITS,
   parameter int ML_BITS          = `SEQ_ML_BITS,
   parameter int OFFSET_BITS      = `SEQ_OFFSET_BITS,
   parameter int BLOCK_BYTES_BITS = 24
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_valid,
   input  logic [LL_BITS-1:0]          i_ll,
   input  logic [ML_BITS-1:0]          i_ml,
   input  logic [OFFSET_BITS-1:0]      i_offset,
   input  logic                        i_delim,
   output logic                        i_ready,
   output logic                        o_valid,
   output logic [LL_BITS-1:0]          o_ll,
   output logic [ML_BITS-1:0]          o_ml,
   output logic [OFFSET_BITS:0]        o_offbase,
   output logic                        o_delim,
   output logic [BLOCK_BYTES_BITS-1:0] o_block_bytes,
   input  logic                        o_ready
);

   localparam int OB_BITS  = OFFSET_BITS + 1;
   localparam int SUM_BITS = BLOCK_BYTES_BITS + 1;

   // Saturate the widened block sum back to the counter width.
   function automatic logic [BLOCK_BYTES_BITS-1:0] f_sat(input logic [SUM_BITS-1:0] sum);
      logic [BLOCK_BYTES_BITS-1:0] res;
      if (sum[SUM_BITS-1]) begin
         res = {BLOCK_BYTES_BITS{1'b1}};
      end else begin
         res = sum[BLOCK_BYTES_BITS-1:0];
      end
      return res;
   endfunction

   // Output stage registers
   logic                        r_valid;
   logic [LL_BITS-1:0]          r_ll;
   logic [ML_BITS-1:0]          r_ml;
   logic [OB_BITS-1:0]          r_offbase;
   logic                        r_delim;
   logic [BLOCK_BYTES_BITS-1:0] r_block_bytes;

   // Running byte count of the block in progress
   logic [BLOCK_BYTES_BITS-1:0] r_cnt;

   logic                        w_ready;
   logic                        w_accept;
   logic [OB_BITS-1:0]          w_off_new;
   logic [OB_BITS-1:0]          w_offbase;
   logic [SUM_BITS-1:0]         w_sum;
   logic [BLOCK_BYTES_BITS-1:0] w_sum_sat;

   // The stage can take a new sequence when empty or when it drains this cycle.
   assign w_ready   = ~r_valid | o_ready;
   assign w_accept  = i_valid & w_ready;
   assign w_off_new = {1'b0, i_offset} + OB_BITS'(3);

   assign i_ready       = w_ready;
   assign o_valid       = r_valid;
   assign o_ll          = r_ll;
   assign o_ml          = r_ml;
   assign o_offbase     = r_offbase;
   assign o_delim       = r_delim;
   assign o_block_bytes = r_block_bytes;

   // Block byte sum, widened by one bit so saturation can be detected.
   always_comb begin
      w_sum     = SUM_BITS'(r_cnt) + SUM_BITS'(i_ll) + SUM_BITS'(i_ml);
      w_sum_sat = f_sat(w_sum);
   end

`ifdef REPCODE_EN
   // Repeat-offset history, most recent first
   logic [OFFSET_BITS-1:0] r_rep1;
   logic [OFFSET_BITS-1:0] r_rep2;
   logic [OFFSET_BITS-1:0] r_rep3;
   logic [OFFSET_BITS-1:0] w_rep1_nxt;
   logic [OFFSET_BITS-1:0] w_rep2_nxt;
   logic [OFFSET_BITS-1:0] w_rep3_nxt;
   logic [OFFSET_BITS-1:0] w_rep1_m1;

   // Choose the offBase code and the history that follows it, from pre-update history.
   always_comb begin
      w_offbase  = w_off_new;
      w_rep1_nxt = i_offset;
      w_rep2_nxt = r_rep1;
      w_rep3_nxt = r_rep2;
      w_rep1_m1  = r_rep1 - OFFSET_BITS'(1);
      if (i_delim) begin
         w_offbase  = OB_BITS'(0);
         w_rep1_nxt = r_rep1;
         w_rep2_nxt = r_rep2;
         w_rep3_nxt = r_rep3;
      end else if (i_ll != LL_BITS'(0)) begin
         // With literals present the repeat slots map to rep1, rep2, rep3.
         if (i_offset == r_rep1) begin
            w_offbase  = OB_BITS'(1);
            w_rep1_nxt = r_rep1;
            w_rep2_nxt = r_rep2;
            w_rep3_nxt = r_rep3;
         end else if (i_offset == r_rep2) begin
            w_offbase  = OB_BITS'(2);
            w_rep1_nxt = r_rep2;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep3;
         end else if (i_offset == r_rep3) begin
            w_offbase  = OB_BITS'(3);
            w_rep1_nxt = r_rep3;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep2;
         end else begin
            w_offbase  = w_off_new;
            w_rep1_nxt = i_offset;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep2;
         end
      end else begin
         // With no literals the slots shift: rep2, rep3, then rep1-1.
         if (i_offset == r_rep2) begin
            w_offbase  = OB_BITS'(1);
            w_rep1_nxt = r_rep2;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep3;
         end else if (i_offset == r_rep3) begin
            w_offbase  = OB_BITS'(2);
            w_rep1_nxt = r_rep3;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep2;
         end else if ((r_rep1 > OFFSET_BITS'(1)) && (i_offset == w_rep1_m1)) begin
            w_offbase  = OB_BITS'(3);
            w_rep1_nxt = w_rep1_m1;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep2;
         end else begin
            w_offbase  = w_off_new;
            w_rep1_nxt = i_offset;
            w_rep2_nxt = r_rep1;
            w_rep3_nxt = r_rep2;
         end
      end
   end

   // History advances only on an accepted sequence and survives block boundaries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rep1 <= OFFSET_BITS'(1);
         r_rep2 <= OFFSET_BITS'(4);
         r_rep3 <= OFFSET_BITS'(8);
      end else if (w_accept) begin
         r_rep1 <= w_rep1_nxt;
         r_rep2 <= w_rep2_nxt;
         r_rep3 <= w_rep3_nxt;
      end else begin
         r_rep1 <= r_rep1;
         r_rep2 <= r_rep2;
         r_rep3 <= r_rep3;
      end
   end
`else
   // Without history every real offset is sent as a new offset.
   always_comb begin
      w_offbase = w_off_new;
      if (i_delim) begin
         w_offbase = OB_BITS'(0);
      end else begin
         w_offbase = w_off_new;
      end
   end
`endif

   // Block byte counter: accumulate within a block, restart after the delimiter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= BLOCK_BYTES_BITS'(0);
      end else if (w_accept) begin
         if (i_delim) begin
            r_cnt <= BLOCK_BYTES_BITS'(0);
         end else begin
            r_cnt <= w_sum_sat;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Output register stage: load on accept, hold while stalled, empty on drain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid       <= 1'b0;
         r_ll          <= LL_BITS'(0);
         r_ml          <= ML_BITS'(0);
         r_offbase     <= OB_BITS'(0);
         r_delim       <= 1'b0;
         r_block_bytes <= BLOCK_BYTES_BITS'(0);
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_ll      <= i_ll;
         r_ml      <= i_ml;
         r_offbase <= w_offbase;
         r_delim   <= i_delim;
         if (i_delim) begin
            r_block_bytes <= w_sum_sat;
         end else begin
            r_block_bytes <= BLOCK_BYTES_BITS'(0);
         end
      end else if (o_ready) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   seq_repcode_encoder_chk #(
      .ML_BITS (ML_BITS)
   ) u_chk (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_accept (w_accept),
      .i_delim  (i_delim),
      .i_ml     (i_ml)
   );

endmodule

// File: doc/seq_repcode_encoder.md
Name: seq_repcode_encoder

Overview:
- Stage directly downstream of the sequence serializer, feeding the entropy-coding stage.
- Accepts the serialized sequence stream (ll, ml, offset, delim) and converts raw offsets to zstd-style offBase codes (1..3 = repeat offset, offset+3 = new offset) using a 3-entry repeat-offset history.
- Accumulates per-block byte count (sum of ll+ml), emitted alongside the delimiter sequence.
- One register stage with standard valid/ready handshake.

Parameters:
LL_BITS, `SEQ_LL_BITS, literal-length width
ML_BITS, `SEQ_ML_BITS, match-length width
OFFSET_BITS, `SEQ_OFFSET_BITS, raw offset width
BLOCK_BYTES_BITS, 24, block byte counter width (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_valid  in  1  input sequence valid
i_ll  in  LL_BITS  literal length
i_ml  in  ML_BITS  match length; 0 only with i_delim
i_offset  in  OFFSET_BITS  raw match offset (>=1 when i_ml!=0)
i_delim  in  1  last sequence of block (literals only)
i_ready  out  1  input accepted when i_valid&i_ready
o_valid  out  1  output sequence valid
o_ll  out  LL_BITS  registered i_ll
o_ml  out  ML_BITS  registered i_ml
o_offbase  out  OFFSET_BITS+1  offBase code; 0 for delim sequences
o_delim  out  1  registered i_delim
o_block_bytes  out  BLOCK_BYTES_BITS  block byte total, valid when o_delim
i_ready/o_ready handshake: o_ready  in  1  downstream ready

Behaviour:
- Reset: o_valid=0, all output data regs 0, rep history {r1,r2,r3}={1,4,8}, block byte counter 0. Reset mid-transfer drops the held sequence.
- Handshake: i_ready = ~o_valid | o_ready. Accept when i_valid&i_ready; output reg loaded the same edge, o_valid=1 next cycle. Latency 1 cycle; full throughput of one sequence per cycle under continuous o_ready. o_valid stays 1 and outputs stay stable until o_ready. When o_ready&~accept: o_valid clears.
- History and counter update only on accept, using pre-update history, so back-to-back sequences see the correct history.
- Encoding, non-delim, ll!=0: offset==r1 -> 1, no change; ==r2 -> 2, swap r1/r2; ==r3 -> 3, {r1,r2,r3}<={r3,r1,r2}; else offset+3, {r1,r2,r3}<={offset,r1,r2}.
- Encoding, non-delim, ll==0: offset==r2 -> 1, swap r1/r2; ==r3 -> 2, {r3,r1,r2}; ==r1-1 and r1>1 -> 3, {r1-1,r1,r2}; else offset+3, {offset,r1,r2}. Priority is r2, r3, r1-1 (ll==0) or r1, r2, r3 (ll!=0) when values coincide.
- Delim sequence (i_delim=1): o_offbase=0, history unchanged. i_ml!=0 with i_delim is a simulation $fatal.
- History persists across blocks. Only rst_n reinitialises it.
- Block counter: on accept, sum = counter + ll + ml (extended to BLOCK_BYTES_BITS+1), saturating at all-ones.
  - Non-delim: counter <= sat(sum), o_block_bytes = 0.
  - Delim: o_block_bytes <= sat(sum), counter <= 0.
- offset+3 computed at OFFSET_BITS+1 bits; no overflow possible.

Optional Feature:
REPCODE_EN
- Defined: repeat-offset encoding and history as above.
- Undefined: no history registers. Non-delim o_offbase = offset+3 always; delim gives 0.
- Handshake, latency and block counter are identical in both builds.

Test Plan:
- Reset, then ll=5,ml=10,off=100, o_ready=1 -> next cycle o_offbase=103. History {100,1,4}.
- After that, ll=2,ml=6,off=1 -> offbase 2, history {1,100,4}. Then ll=3,ml=4,off=4 -> offbase 3, history {4,1,100}.
- History {4,1,100}, ll=0,off=1 -> offbase 1, history {1,4,100}. Then ll=0,off=0x0 is illegal; instead ll=0 with r1=5, off=4 -> offbase 3, history {4,5,...}.
- Sequences ll=10/ml=20, ll=7/ml=3, then delim ll=12 -> o_block_bytes=52, o_offbase=0. Next block counts from 0.
- o_ready held 0 for 4 cycles with i_valid=1 -> i_ready=0 after first accept, outputs stable. Release gives in-order output with no loss or duplicate.
- REPCODE_EN undefined, same stream as scenario 2 -> offbase 103, 4, 7. Counter is 0x00FFFFF0 before a ll=0x20 sequence -> the delim reports 0xFFFFFF (saturated).
